rx_control_module: RTL

- UART 8N1 receive controller: the receiving end of the serial line driven by the team's transmit controller.
- Synchronises the raw RX pin and detects the start-bit falling edge.
- Times each bit with an internal divider and samples it at mid-bit.
- Assembles the byte LSB first and reports it with a one-cycle done pulse, or flags a framing error.

---
 rtl/rx_control_module_pkg.sv | 19 +
 rtl/rx_sync_edge.sv | 28 ++
 rtl/rx_control_module.sv | 119 +++++++++++
 3 files changed

// File: rtl/rx_control_module_pkg.sv
// Shared definitions for the UART 8N1 receive controller: state encoding, frame shape and the
// default bit period, which is also used by the transmit baud generator.
package rx_control_module_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } rx_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned STOP_SLOT       = 9;
  // 50 MHz / 115200 baud
  localparam int unsigned BPS_DIV_DEFAULT = 434;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous RX line, plus a history flop that yields a
// one-cycle pulse on each falling edge. Resets to line-high so reset release is not an edge.
module rx_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rx_sync_o = sync_q;
  assign fall_o    = hist_q & ~sync_q;

endmodule

// File: rtl/rx_control_module.sv
// UART 8N1 receiver: mid-bit sampling with an internal divider, LSB-first assembly, done/error
// pulses. Define RX_MAJORITY_VOTE_EN for 2-of-3 voting around mid-bit (adds one cycle latency).
module rx_control_module
  import rx_control_module_pkg::*;
#(
  parameter int unsigned BPS_DIV = BPS_DIV_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Rx_En_Sig,
  input  logic       Rx_Pin_In,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Rx_Err_Sig
);

  localparam int unsigned BPS_HALF = BPS_DIV / 2;
  localparam int unsigned CntW     = $clog2(BPS_DIV);

  rx_state_e     state_q;
  logic [CntW-1:0] cnt_q, cnt_next;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q, data_q;
  logic          done_q, err_q;
  logic          rx_sync, fall;
  logic          strobe, bit_val;

  rx_sync_edge u_sync_edge (
    .clk_i    (CLK),
    .rst_ni   (RST_n),
    .rx_i     (Rx_Pin_In),
    .rx_sync_o(rx_sync),
    .fall_o   (fall)
  );

  assign cnt_next = (cnt_q == CntW'(BPS_DIV - 1)) ? '0 : cnt_q + 1'b1;

`ifdef RX_MAJORITY_VOTE_EN
  logic s0_q, s1_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (cnt_q == CntW'(BPS_HALF - 1)) s0_q <= rx_sync;
      if (cnt_q == CntW'(BPS_HALF))     s1_q <= rx_sync;
    end
  end

  // Third vote is the live sample, so the decision lands one cycle after mid-bit.
  assign strobe  = (cnt_q == CntW'(BPS_HALF + 1));
  assign bit_val = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);
`else
  assign strobe  = (cnt_q == CntW'(BPS_HALF));
  assign bit_val = rx_sync;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!Rx_En_Sig) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        // The edge-detect cycle counts as divider value 0.
        if (state_q == StIdle) cnt_q <= fall ? CntW'(1) : '0;
        else                   cnt_q <= cnt_next;

        unique case (state_q)
          StIdle: begin
            if (fall) state_q <= StStart;
          end
          StStart: begin
            if (strobe) begin
              idx_q   <= '0;
              state_q <= bit_val ? StIdle : StData;
            end
          end
          StData: begin
            if (strobe) begin
              shift_q[idx_q] <= bit_val;
              idx_q          <= idx_q + 1'b1;
              if (idx_q == 3'(FRAME_DATA_BITS - 1)) state_q <= StStop;
            end
          end
          StStop: begin
            if (strobe) begin
              if (bit_val) begin
                state_q <= StDone;
                data_q  <= shift_q;
                done_q  <= 1'b1;
              end else begin
                state_q <= StErr;
                err_q   <= 1'b1;
              end
            end
          end
          StDone, StErr: state_q <= StIdle;
          default:       state_q <= StIdle;
        endcase
      end
    end
  end

  assign Rx_Data     = data_q;
  assign Rx_Done_Sig = done_q;
  assign Rx_Err_Sig  = err_q;

endmodule
